fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Parametrised program-counter and fetch sequencer for the single-cycle core.
//   Adds stall, PC-relative/absolute branches, call/return via a hardware return
//   stack, and a sticky halt on the all-ones instruction.
//   Sits between control/branch resolution and instr_ROM; drives prog_ctr and done.
// PARAMETERS
//   D      10  program counter width (bits)
//   IW      9  machine-code width; all-ones word = halt
//   SD      4  return-stack depth (entries, >=1)
//   START   0  reset value of prog_ctr
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   reset      in   1   synchronous, active-high; clears all state
//   stall      in   1   hold prog_ctr and stack this cycle
//   branch_en  in   1   take branch this cycle
//   branch_abs in   1   1: target is absolute address; 0: signed PC-relative offset
//   target     in   D   branch/call address or two's-complement offset
//   call_en    in   1   absolute jump to target, push prog_ctr+1
//   ret_en     in   1   pop return address into prog_ctr
//   mach_code  in   IW  instruction currently at prog_ctr (combinational ROM output)
//   prog_ctr   out  D   current fetch address
//   done       out  1   sticky halt indicator
//   stack_err  out  1   sticky return-stack overflow/underflow flag
// BEHAVIOUR
//   - Reset (sync, high): prog_ctr=START, done=0, stack_err=0, stack ptr=0, state=RUN.
//     Reset mid-operation discards stack contents and any pending control.
//   - FSM: RUN, HALT. RUN->HALT when mach_code=='1 and !stall; HALT->RUN on reset only.
//   - done = (state==HALT), registered: asserts the cycle after the halt word is fetched.
//   - Next-PC priority (evaluated in RUN, one-cycle latency, applied next edge):
//     halt word > stall > ret_en > call_en > branch_en > prog_ctr+1.
//     * halt word / stall: prog_ctr holds; stack unchanged.
//     * ret_en: stack non-empty -> prog_ctr=top, pop. Empty -> prog_ctr+1, stack_err=1.
//     * call_en: prog_ctr=target; push prog_ctr+1. Full -> jump still taken, push
//       dropped, stack_err=1.
//     * branch_en & branch_abs: prog_ctr=target.
//     * branch_en & !branch_abs: prog_ctr=prog_ctr+target, modulo 2^D.
//     * default: prog_ctr+1, wraps 2^D-1 -> 0.
//   - Lower-priority requests asserted with a winner are ignored, not queued.
//   - In HALT all inputs except reset are ignored; prog_ctr frozen.
//   - stack_err sticky until reset; stack remains usable after error.
//   - Pushed return address computed modulo 2^D.
// STRUCTURE
//   - fetch_pkg: typedef enum {RUN,HALT} fetch_state_t; typedef enum
//     {NPC_HOLD,NPC_RET,NPC_CALL,NPC_ABS,NPC_REL,NPC_INC} npc_sel_t.
//   - Sub-module ret_stack #(D,SD): LIFO with push, pop, top, full, empty;
//     push/pop on same edge never issued by fetch_unit. Pointer width $clog2(SD+1).
//   - fetch_unit: FSM, priority encoder -> npc_sel_t, next-PC mux, error/done regs.
// TESTING
//   1 Reset: START=0, run 3 cycles no control -> prog_ctr 0,1,2,3; done=0, stack_err=0.
//   2 Rel branch: prog_ctr=5, branch_en=1, branch_abs=0, target=10'h3FE (-2)
//     -> prog_ctr=3 next cycle; prog_ctr=1023 + inc -> 0.
//   3 Call/ret: prog_ctr=8, call_en, target=40 -> 40; two incs -> 42; ret_en -> 9.
//   4 Overflow/underflow (SD=4): 5 nested calls -> 5th jumps, stack_err=1; 4 rets
//     return correct addresses; 5th ret -> prog_ctr+1, stack_err stays 1.
//   5 Priority: ret_en+call_en+branch_en same cycle -> ret wins; stall+ret_en -> hold,
//     stack depth unchanged.
//   6 Halt: mach_code=9'h1FF at prog_ctr=20 -> done=1 next edge, prog_ctr stays 20
//     under branch/call; reset -> prog_ctr=0, done=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch sequencer: FSM state and next-PC source select.
package fetch_pkg;

   typedef enum logic [0:0] {
      RUN,
      HALT
   } fetch_state_t;

   typedef enum logic [2:0] {
      NPC_HOLD,
      NPC_RET,
      NPC_CALL,
      NPC_ABS,
      NPC_REL,
      NPC_INC
   } npc_sel_t;

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Hardware return-address LIFO; the owner never pushes and pops on the same edge.
module ret_stack
   import fetch_pkg::*;
#(
   parameter int unsigned D  = 10,
   parameter int unsigned SD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [D-1:0] din,
   output logic [D-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(SD + 1);

   logic [PW-1:0] ptr;
   logic [D-1:0]  mem [SD];

   assign full  = (ptr == PW'(SD));
   assign empty = (ptr == '0);

   // ptr counts occupied entries, so the top lives at ptr-1
   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < SD; i++) begin
         if (ptr == PW'(i + 1)) top = mem[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         for (int unsigned i = 0; i < SD; i++) mem[i] <= '0;
      end else if (push && !full) begin
         for (int unsigned i = 0; i < SD; i++) begin
            if (ptr == PW'(i)) mem[i] <= din;
         end
         ptr <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer with stall, branches, call/return stack and sticky halt.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned D     = 10,
   parameter int unsigned IW    = 9,
   parameter int unsigned SD    = 4,
   parameter int unsigned START = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          branch_en,
   input  logic          branch_abs,
   input  logic [D-1:0]  target,
   input  logic          call_en,
   input  logic          ret_en,
   input  logic [IW-1:0] mach_code,
   output logic [D-1:0]  prog_ctr,
   output logic          done,
   output logic          stack_err
);

   fetch_state_t state, state_nxt;
   npc_sel_t     sel;
   logic [D-1:0] pc_inc, pc_nxt, stk_top;
   logic         halt_word, stk_full, stk_empty, push, pop, err_set;

   assign halt_word = &mach_code;
   assign pc_inc    = prog_ctr + D'(1);
   assign done      = (state == HALT);

   always_comb begin
      state_nxt = state;
      sel       = NPC_INC;
      if (state == HALT || halt_word || stall) begin
         sel = NPC_HOLD;
         if (state == RUN && halt_word && !stall) state_nxt = HALT;
      end else if (ret_en)    sel = NPC_RET;
      else if (call_en)       sel = NPC_CALL;
      else if (branch_en)     sel = branch_abs ? NPC_ABS : NPC_REL;
   end

   always_comb begin
      pc_nxt = pc_inc;
      unique case (sel)
         NPC_HOLD: pc_nxt = prog_ctr;
         NPC_RET:  pc_nxt = stk_empty ? pc_inc : stk_top;
         NPC_CALL: pc_nxt = target;
         NPC_ABS:  pc_nxt = target;
         NPC_REL:  pc_nxt = prog_ctr + target;
         NPC_INC:  pc_nxt = pc_inc;
         default:  pc_nxt = pc_inc;
      endcase
   end

   // a call on a full stack still jumps; only the push is lost
   assign push    = (sel == NPC_CALL) && !stk_full;
   assign pop     = (sel == NPC_RET) && !stk_empty;
   assign err_set = ((sel == NPC_CALL) && stk_full) || ((sel == NPC_RET) && stk_empty);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         prog_ctr  <= D'(START);
         stack_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         prog_ctr <= pc_nxt;
         if (err_set) stack_err <= 1'b1;
      end
   end

   ret_stack #(
      .D  (D),
      .SD (SD)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

endmodule
